// File: rtl/pipelined_adder.sv
`timescale 1ns/1ps
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks,
// one chunk rippled per stage, carry registered between stages, latency STAGES.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int CW = WIDTH / STAGES;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : c_in;

    // Stage k consumes the low chunk of its source operands and forwards the
    // remaining upper bits (skew); finished sum chunks accumulate in s_acc (deskew).
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW = WIDTH - k * CW;

        logic [SW-1:0]         a_src;
        logic [SW-1:0]         b_src;
        logic                  c_src;
        logic                  v_src;
        logic [CW:0]           add_res;
        logic [(k+1)*CW-1:0]   s_acc;
        logic                  c_reg;
        logic                  v_reg;

        if (k == 0) begin : g_src
            assign a_src = a;
            assign b_src = b_eff;
            assign c_src = cin_eff;
            assign v_src = in_valid;
        end else begin : g_src
            assign a_src = g_stage[k-1].g_rem.a_rem;
            assign b_src = g_stage[k-1].g_rem.b_rem;
            assign c_src = g_stage[k-1].c_reg;
            assign v_src = g_stage[k-1].v_reg;
        end

        assign add_res = {1'b0, a_src[CW-1:0]} + {1'b0, b_src[CW-1:0]}
                       + {{CW{1'b0}}, c_src};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_reg <= 1'b0;
                c_reg <= 1'b0;
            end else begin
                v_reg <= v_src;
                if (v_src) c_reg <= add_res[CW];
            end
        end

        if (k == 0) begin : g_sum
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     s_acc <= '0;
                else if (v_src) s_acc <= add_res[CW-1:0];
            end
        end else begin : g_sum
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     s_acc <= '0;
                else if (v_src) s_acc <= {add_res[CW-1:0], g_stage[k-1].s_acc};
            end
        end

        if (k < STAGES - 1) begin : g_rem
            logic [SW-CW-1:0] a_rem;
            logic [SW-CW-1:0] b_rem;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem <= '0;
                    b_rem <= '0;
                end else if (v_src) begin
                    a_rem <= a_src[SW-1:CW];
                    b_rem <= b_src[SW-1:CW];
                end
            end
        end

        // The last stage still holds the operand MSBs, so overflow is formed here.
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    ovf_reg <= 1'b0;
                else if (v_src)
                    ovf_reg <= (a_src[SW-1] == b_src[SW-1]) &&
                               (add_res[CW-1] != a_src[SW-1]);
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_reg;
    assign sum       = g_stage[STAGES-1].s_acc;
    assign c_out     = g_stage[STAGES-1].c_reg;
    assign overflow  = g_stage[STAGES-1].g_ovf.ovf_reg;

endmodule

// File: tb/tb_pipelined_adder.sv
`timescale 1ns/1ps
// Scoreboard bench for pipelined_adder over (8,4), (8,1), (8,8) and (32,4).
module tb_pipelined_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic        c_in, sub;
    logic        hvalid;
    logic [9:0]  hexp;   // hand-computed {overflow, c_out, sum[7:0]} for 8-bit configs
    int          n_cmp = 0;
    int          n_err = 0;
    event        done;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int cfg, input logic [33:0] got, input logic [33:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL cfg%0d %s: got %h, expected %h at %0t", cfg, nm, got, want, $time);
        end
    endtask

    function automatic logic [33:0] model(input int w, input logic [31:0] va, input logic [31:0] vb,
                                          input logic vc, input logic vs);
        logic [31:0] bb;
        logic [32:0] r;
        logic        cc, am, bm, sm, co;
        logic [31:0] s;
        bb = vs ? ~vb : vb;
        cc = vs ? 1'b1 : vc;
        if (w == 32) begin
            r  = {1'b0, va} + {1'b0, bb} + {32'd0, cc};
            co = r[32]; am = va[31]; bm = bb[31]; sm = r[31]; s = r[31:0];
        end else begin
            r  = {25'd0, va[7:0]} + {25'd0, bb[7:0]} + {32'd0, cc};
            co = r[8]; am = va[7]; bm = bb[7]; sm = r[7]; s = {24'd0, r[7:0]};
        end
        return {(am == bm) && (sm != am), co, s};
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_cfg
        localparam int W = (i == 3) ? 32 : 8;
        localparam int S = (i == 1) ? 1 : (i == 2) ? 8 : 4;

        logic         ov, co, ovf;
        logic [W-1:0] s;
        logic [33:0]  q_exp[$];
        time          q_t[$];
        logic [33:0]  last = '0;

        pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
            .a(a[W-1:0]), .b(b[W-1:0]), .c_in(c_in), .sub(sub),
            .out_valid(ov), .sum(s), .c_out(co), .overflow(ovf)
        );

        always @(posedge clk) begin
            if (rst_n && in_valid) begin
                if (W == 8 && hvalid) q_exp.push_back({hexp[9:8], 24'd0, hexp[7:0]});
                else                  q_exp.push_back(model(W, a, b, c_in, sub));
                q_t.push_back($time);
            end
        end

        always @(negedge clk) begin
            logic [33:0] got, e;
            time         t0;
            if (rst_n) begin
                got = 34'(s);
                got[33:32] = {ovf, co};
                if (ov) begin
                    if (q_exp.size() == 0) begin
                        chk("unexpected_out_valid", i, 34'd1, 34'd0);
                    end else begin
                        e  = q_exp.pop_front();
                        t0 = q_t.pop_front();
                        chk("result", i, got, e);
                        chk("latency", i, 34'($time - t0), 34'((S - 1) * 10 + 5));
                    end
                    last = got;
                end else begin
                    chk("hold", i, got, last);
                end
            end
        end

        always @(negedge rst_n) begin
            q_exp.delete();
            q_t.delete();
            last = '0;
            #1;
            if (!rst_n) chk("reset_outputs", i, {ovf, co, 32'(s)}, 34'(ov));
        end

        initial begin
            #2;
            chk("reset_state", i, {ovf, co, 32'(s)} | 34'(ov), 34'd0);
        end

        initial begin
            @(done);
            chk("drained", i, 34'(q_exp.size()), 34'd0);
        end
    end

    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vc, input logic vs,
                         input logic hv, input logic [9:0] he);
        @(negedge clk);
        in_valid = 1'b1; a = va; b = vb; c_in = vc; sub = vs; hvalid = hv; hexp = he;
    endtask

    task automatic bubble();
        @(negedge clk);
        in_valid = 1'b0; a = 'x; b = 'x; c_in = 1'bx; sub = 1'bx; hvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        hvalid = 1'b0; hexp = '0;
        #22 rst_n = 1'b1;

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, {2'b01, 8'h00});
        repeat (9) bubble();
        issue(32'h0000_007F, 32'h0000_0000, 1'b1, 1'b0, 1'b1, {2'b10, 8'h80});
        issue(32'h0000_0080, 32'h0000_0080, 1'b0, 1'b0, 1'b1, {2'b11, 8'h00});
        issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1, {2'b00, 8'hFE});
        issue(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 1'b1, {2'b01, 8'h02});
        bubble();
        issue(32'h0000_0080, 32'h0000_0001, 1'b0, 1'b1, 1'b1, {2'b11, 8'h7F});
        repeat (10) bubble();

        for (int n = 0; n < 256; n++) begin
            if ($urandom_range(3) == 0) bubble();
            else issue($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 10'd0);
        end
        repeat (10) bubble();

        issue(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 1'b1, {2'b00, 8'h33});
        issue(32'h0000_0040, 32'h0000_0040, 1'b0, 1'b0, 1'b1, {2'b10, 8'h80});
        issue(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 1'b1, {2'b00, 8'hF0});
        bubble();
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        issue(32'h0000_0034, 32'h0000_0012, 1'b0, 1'b0, 1'b1, {2'b00, 8'h46});
        repeat (14) bubble();

        -> done;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; it generalises the team's fixed 4-bit ripple-carry adder.
- Operands of WIDTH bits are split into STAGES equal chunks. Each pipeline stage ripples one chunk and registers its carry into the next stage.
- One result per cycle at full throughput, with a valid-tagged streaming interface.
- Used in datapaths where a full-width ripple chain misses timing.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/control valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry in; used only when sub=0.
- sub  input  1  0: a+b+c_in; 1: a-b (a+~b+1).
- out_valid  output  1  result valid.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  raw carry out of the MSB. For subtract, c_out=1 means no borrow.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset: asserting rst_n low immediately and asynchronously clears every register, so out_valid, sum, c_out and overflow all read 0. Any transactions in flight are discarded, not completed.
- After reset release:
  - The first in_valid is accepted on the first rising edge where rst_n is high.
  - No warm-up cycles are required.
- Operand preparation in the input stage, combinational from the inputs:
  - b_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : c_in.
- Stage k (k=0..STAGES-1) pipeline:
  - Stage k adds chunk k of a and b_eff (bits k*CW .. k*CW+CW-1) plus the carry registered from stage k-1. Stage 0 uses cin_eff instead.
  - Stage k registers the resulting CW-bit sum chunk and its carry.
  - Skew: each chunk's operands are delayed by k registers before stage k uses them.
  - Deskew: each sum chunk is delayed by (STAGES-1-k) registers so that all chunks align at the output.
  - The MSB operand bits a[WIDTH-1] and b_eff[WIDTH-1] travel with the pipeline for the overflow calculation.
- Latency: exactly STAGES cycles.
  - An input sampled at edge n appears on out_valid/sum/c_out/overflow after edge n+STAGES-1.
  - Outputs are registered, with no combinational path from input to output.
  - With STAGES=1 this is a registered full-width adder, latency 1.
- Valid pipeline:
  - A 1-bit valid shift register of depth STAGES runs alongside the data; out_valid is its last bit.
  - There is no backpressure: one transaction is accepted per cycle whenever in_valid=1.
- Bubbles:
  - Each data register at a stage loads only when the valid bit entering that stage is 1.
  - When out_valid=0, sum/c_out/overflow hold the last valid result (0 after reset).
  - Bubbles never corrupt in-flight transactions. For example, valid,0,valid produces two correct results two cycles apart.
- Output flags:
  - c_out is the carry out of bit WIDTH-1 of a + b_eff + cin_eff.
  - overflow = (a_msb == b_eff_msb) && (sum_msb != a_msb).
- sub and c_in are sampled per transaction, so add and subtract may be interleaved on consecutive cycles.
- X on a, b, c_in or sub while in_valid=0 must not propagate to the outputs.

Test Plan (WIDTH=8, STAGES=4 unless stated):
- Carry chain: a=8'hFF, b=8'h01, c_in=0, sub=0, one valid pulse -> 4 cycles later out_valid=1 for exactly 1 cycle with sum=8'h00, c_out=1, overflow=0.
- Signed overflow and c_in: a=8'h7F, b=8'h00, c_in=1 -> sum=8'h80, c_out=0, overflow=1. Then a=8'h80, b=8'h80, c_in=0 -> sum=8'h00, c_out=1, overflow=1.
- Subtract: a=8'h05, b=8'h07, sub=1, c_in=1 (must be ignored) -> sum=8'hFE, c_out=0, overflow=0. Then a=8'h07, b=8'h05 -> sum=8'h02, c_out=1.
- Streaming: 256 back-to-back random transactions with random sub and random bubbles -> every result matches the reference model in order, 4 cycles after its input; sum holds its value whenever out_valid=0.
- Reset mid-operation: three transactions in flight, then pulse rst_n low for 3 ns between edges -> all outputs go to 0 immediately, none of the three results ever appears, and a new transaction after release emerges correctly 4 cycles later.
- Parameter sweep: (WIDTH,STAGES) = (8,1), (8,8), (32,4), each with exhaustive or random checks including all-ones+1 -> latency equals STAGES and results match the model.
